sipo_deser_rx: RTL and testbench

//  Receive end of the serial shift link: collects bits driven by the parallel-load/shift-left transmitter
//  (MSB first from its SO) into N-bit words. Completed words pass through a one-entry holding register
//  to a valid/ready consumer. Framing is by bit count, with an explicit resync input.

---
 rtl/sipo_deser_rx_pkg.sv | 9 +
 rtl/sipo_shift_core.sv | 58 +++++
 rtl/sipo_deser_rx.sv | 81 ++++++++
 tb/tb_sipo_deser_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sipo_deser_rx_pkg.sv
// Shared constants and helpers for the serial-to-parallel receiver.
package sipo_deser_rx_pkg;

    // Width of a bit counter that must hold 0..n-1 (never narrower than one bit).
    function automatic int cw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter: assembles serial bits into one N-bit word.
module sipo_shift_core
    import sipo_deser_rx_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = cw_of(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          SI,
    input  logic          clr,
    output logic [CW-1:0] bit_cnt,
    output logic          word_done,
    output logic [N-1:0]  word
);

    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    logic [N-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe;

    // Resync discards the strobe on the same cycle.
    assign strobe = en & ~clr;

    // Next-state shift value, completion detect and counter wrap.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        word      = MSB_FIRST ? {sh_q[N-2:0], SI} : {SI, sh_q[N-1:1]};
        word_done = strobe && (cnt_q == LAST_BIT);
        if (clr) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (en) begin
            sh_d  = word;
            cnt_d = (cnt_q == LAST_BIT) ? '0 : cnt_q + CW'(1);
        end
    end

    // Shift state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_cnt = cnt_q;

endmodule

// File: rtl/sipo_deser_rx.sv
// Serial receiver: shift core feeding a one-entry valid/ready holding register with sticky overrun.
module sipo_deser_rx
    import sipo_deser_rx_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = cw_of(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          SI,
    input  logic          sync,
    output logic [N-1:0]  dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [CW-1:0] bit_cnt,
    output logic          overrun,
    input  logic          ovr_clr
);

    logic          word_done;
    logic [N-1:0]  word;
    logic [N-1:0]  hold_q, hold_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    sipo_shift_core #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .SI        (SI),
        .clr       (sync),
        .bit_cnt   (bit_cnt),
        .word_done (word_done),
        .word      (word)
    );

    // Holding register: consume, load (possibly on the consume edge) or drop-and-flag overrun.
    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (word_done) begin
            if (!valid_q || dout_ready) begin
                hold_d  = word;
                valid_d = 1'b1;
            end else begin
                // Set beats a simultaneous clear.
                ovr_d = 1'b1;
            end
        end
    end

    // Output-side registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = hold_q;
    assign dout_valid = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deser_rx.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor pops them on each handshake.
module tb_sipo_deser_rx;

    logic       clk = 1'b0;
    logic       rst_n, en, SI, sync, dout_ready, ovr_clr;
    logic [7:0] dout;
    logic       dout_valid, overrun;
    logic [2:0] bit_cnt;

    logic       en2, si2, ready2;
    logic [7:0] dout2;
    logic       valid2, ovr2;
    logic [2:0] cnt2;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx;

    always #5 clk = ~clk;

    sipo_deser_rx #(.N(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .SI(SI), .sync(sync),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .bit_cnt(bit_cnt), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    sipo_deser_rx #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .en(en2), .SI(si2), .sync(1'b0),
        .dout(dout2), .dout_valid(valid2), .dout_ready(ready2),
        .bit_cnt(cnt2), .overrun(ovr2), .ovr_clr(1'b0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            en = 1'b1;
            SI = w[i];
            tick();
        end
        en = 1'b0;
        SI = 1'b0;
    endtask

    task automatic send_word_lsb(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            en2 = 1'b1;
            si2 = w[i];
            tick();
        end
        en2 = 1'b0;
        si2 = 1'b0;
    endtask

    // Monitor: every consumed word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h, expected none", dout);
            end else begin
                check("scoreboard_word", {24'h0, dout}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; SI = 1'b0; sync = 1'b0; dout_ready = 1'b0; ovr_clr = 1'b0;
        en2 = 1'b0; si2 = 1'b0; ready2 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // 1: reset state, then reset in the middle of a word
        check("rst_dout", {24'h0, dout}, 32'h0);
        check("rst_valid", {31'h0, dout_valid}, 32'h0);
        check("rst_bit_cnt", {29'h0, bit_cnt}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; SI = 1'b1; tick();
        end
        en = 1'b0;
        check("partial_bit_cnt", {29'h0, bit_cnt}, 32'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midword_rst_bit_cnt", {29'h0, bit_cnt}, 32'h0);
        check("midword_rst_valid", {31'h0, dout_valid}, 32'h0);
        dout_ready = 1'b1;
        exp_q.push_back(8'hF0);
        send_word(8'hF0);
        tick();

        // 2: basic word, valid the cycle after the 8th strobe
        exp_q.push_back(8'hA5);
        send_word(8'hA5);
        check("a5_valid", {31'h0, dout_valid}, 32'h1);
        check("a5_dout", {24'h0, dout}, 32'hA5);
        tick();
        check("a5_consumed", {31'h0, dout_valid}, 32'h0);

        // 3: back-to-back, consume on the edge the second word completes
        dout_ready = 1'b0;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] pat;
            pat = 16'h3CC3;
            en = 1'b1;
            SI = pat[15 - i];
            dout_ready = (i == 15);
            tick();
        end
        en = 1'b0;
        check("b2b_valid", {31'h0, dout_valid}, 32'h1);
        check("b2b_dout", {24'h0, dout}, 32'hC3);
        check("b2b_overrun", {31'h0, overrun}, 32'h0);
        tick();
        dout_ready = 1'b0;
        check("b2b_drained", {31'h0, dout_valid}, 32'h0);

        // 4: overrun keeps the old word, clear, then drain
        exp_q.push_back(8'h11);
        send_word(8'h11);
        send_word(8'h22);
        check("ovr_dout", {24'h0, dout}, 32'h11);
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        check("ovr_valid", {31'h0, dout_valid}, 32'h1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_cleared", {31'h0, overrun}, 32'h0);
        dout_ready = 1'b1;
        tick();
        check("ovr_drained", {31'h0, dout_valid}, 32'h0);

        // 5: resync discards a partial word and the same-cycle strobe
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; SI = i[0]; tick();
        end
        sync = 1'b1; en = 1'b1; SI = 1'b1;
        tick();
        sync = 1'b0; en = 1'b0; SI = 1'b0;
        check("sync_bit_cnt", {29'h0, bit_cnt}, 32'h0);
        exp_q.push_back(8'h5A);
        send_word(8'h5A);
        tick();

        // 6a: LSB-first instance, first bit lands in dout[0]
        send_word_lsb(8'h01);
        check("lsb_valid", {31'h0, valid2}, 32'h1);
        check("lsb_dout", {24'h0, dout2}, 32'h01);
        check("lsb_bit_cnt", {29'h0, cnt2}, 32'h0);
        check("lsb_overrun", {31'h0, ovr2}, 32'h0);

        // 6b: loopback from a parallel-load shift-left transmitter (SO = MSB)
        tx = 8'h96;
        exp_q.push_back(8'h96);
        for (int i = 0; i < 8; i++) begin
            en = 1'b1;
            SI = tx[7];
            tick();
            tx = {tx[6:0], 1'b0};
        end
        en = 1'b0;
        check("loop_dout", {24'h0, dout}, 32'h96);
        tick();
        tick();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
